fpu_result_queue: RTL and testbench
===================================

# fpu_result_queue

Registered output stage directly downstream of the combinational FP32 adder/subtractor. It captures each `{result, exception, op}` triple the adder produces into a small FIFO with valid/ready handshakes on both sides. This decouples the adder from a slower consumer (register file write-back or bus interface). It also classifies each queued result and keeps a sticky exception flag plus a saturating exception counter for status reporting.

## Interface
- `DEPTH`, default 4: number of queue entries; power of two, at least 2.
- `CNT_W`, default 8: width of the exception counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the adder result on `in_*` is valid this cycle.
- `in_ready`  out  1  the queue can accept an entry this cycle.
- `in_result`  in  32  IEEE-754 single result from the adder.
- `in_exception`  in  1  adder exception flag (overflow/underflow/zero exponent).
- `in_op`  in  1  operation that produced the result: 0 = add, 1 = sub.
- `out_valid`  out  1  the head entry is presented on `out_*`.
- `out_ready`  in  1  the consumer takes the head entry this cycle.
- `out_result`  out  32  head entry result.
- `out_exception`  out  1  head entry exception flag.
- `out_op`  out  1  head entry op bit.
- `out_is_zero`  out  1  `out_result[30:0] == 0`; sign ignored.
- `out_sign`  out  1  `out_result[31]`.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `sticky_exception`  out  1  set by any accepted entry with `in_exception = 1`.
- `exc_count`  out  CNT_W  number of accepted exception entries; saturates at all-ones.
- `clear_sticky`  in  1  synchronous clear of `sticky_exception` and `exc_count`.

## Operation
- **Storage.** Circular buffer of DEPTH 34-bit entries `{op, exception, result}`.
  - Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - `count` is a separate register.
- **Push.** Occurs when `in_valid && in_ready`.
  - The entry is written at the write pointer, and the write pointer increments.
  - The entry is stored verbatim; the queue does not alter the result. An exception entry already carries 0 from the adder.
- **Pop.** Occurs when `out_valid && out_ready`; the read pointer increments.
- **Ready/valid.** `in_ready = !rst && (count != DEPTH)`. `out_valid = (count != 0)`.
  - Both are derived from registered state only. They never depend combinationally on `in_valid` or `out_ready`.
- **Occupancy.** `count` changes by +1 on push only, -1 on pop only, and 0 on push and pop together.
- **Full.** `in_ready = 0`, so no push occurs even if a pop happens the same cycle. There is no pass-through on full, and the freed slot becomes available the next cycle.
- **Empty.** `out_valid = 0`, so no pop occurs. A push into an empty queue is not bypassed to the output in the same cycle.
- **Output presentation.** `out_*` are driven from the entry at the read pointer (first-word fall-through).
  - `out_is_zero` and `out_sign` are decoded combinationally from that entry.
  - While `out_valid = 0`, `out_*` hold the stale entry value. Consumers ignore them.
- **Status.** On an accepted push with `in_exception = 1`:
  - `sticky_exception` is set to 1.
  - `exc_count` increments, holding at 2^CNT_W-1.
- **Clear.** `clear_sticky = 1` clears both status registers. If the same cycle also accepts an exception push, set wins: `sticky_exception = 1` and `exc_count = 1`.
- **Status scope.** Status is unaffected by pops. Only pushes are counted.

## Timing
- **Reset.** While `rst = 1` at a rising edge, the following are cleared:
  - `count = 0`, both pointers = 0, `sticky_exception = 0`, `exc_count = 0`.
  - After that edge, `out_valid = 0`, and `out_is_zero`/`out_sign` reflect stale storage.
  - `in_ready = 0` while `rst` is high; `in_ready = 1` the first cycle after `rst` deasserts.
  - Storage contents are not reset.
- **Reset mid-operation.** All queued entries are discarded, and a push or pop in the reset cycle is ignored.
- **Latency.** An entry pushed at edge N is visible on `out_*` with `out_valid = 1` from just after edge N. The earliest pop is at edge N+1, giving a one-cycle minimum input-to-consume latency.
- **Throughput.** One push and one pop per cycle are sustained whenever `0 < count < DEPTH`.
- **Status timing.** `sticky_exception` and `exc_count` update at the edge of the accepting push and are visible the following cycle.

## Test plan
- **Order.** Reset, then push 0x40400000 (op 0), 0x3F800000 (op 1), 0x00000000 (exc 1) with `out_ready = 0`. Then pop all three.
  - Required: `count` goes 1,2,3 and then 2,1,0, and entries emerge in push order.
  - The third entry shows `out_is_zero = 1` and `out_exception = 1`.
- **Fill and drain.** Push DEPTH=4 entries.
  - Required: `in_ready = 0` at `count = 4`. A 5th `in_valid` is not accepted, and `count` stays 4 with simultaneous `out_ready = 1` that cycle.
  - Next cycle `in_ready = 1`.
- **Streaming.** Hold `in_valid = out_ready = 1` for 20 cycles with incrementing results, starting from a primed queue of 1 entry.
  - Required: `count` stays 1, there are no drops or duplicates, and the pointers wrap correctly at least 4 times.
- **Status.** Push 3 exception entries, then assert `clear_sticky` alongside a 4th exception push.
  - Required: `exc_count` = 3 before the clear, then 1 after; `sticky_exception` stays 1.
  - Separately, with `CNT_W = 2`, 5 exception pushes give `exc_count = 3`.
- **Reset mid-operation.** With 3 entries queued, assert `rst` for 1 cycle while pushing and popping.
  - Required: after reset `count = 0`, `out_valid = 0`, `sticky_exception = 0`, `exc_count = 0`.
  - `in_ready = 0` during `rst`, then 1.

Source files
------------

// File: rtl/fpu_result_queue.sv
// fpu_result_queue: registered FIFO stage behind the FP32 add/sub unit.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     producer handshake; in_result, in_exception, in_op
//   out_valid/out_ready   consumer handshake; out_result, out_exception, out_op
//   out_is_zero, out_sign head-entry classification
//   count                 occupancy 0..DEPTH
//   sticky_exception      set by any accepted exception entry
//   exc_count             saturating count of accepted exception entries
//   clear_sticky          clears sticky_exception and exc_count
module fpu_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_result,
    input  logic                       in_exception,
    input  logic                       in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_result,
    output logic                       out_exception,
    output logic                       out_op,
    output logic                       out_is_zero,
    output logic                       out_sign,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       sticky_exception,
    output logic [CNT_W-1:0]           exc_count,
    input  logic                       clear_sticky
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [CNT_W-1:0] EXC_MAX = '1;

    logic [33:0]      mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] exc_q, exc_d;
    logic [33:0]      head;
    logic             push, pop;

    // Handshakes depend on registered state (and rst) only.
    assign in_ready  = !rst && (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head          = mem_q[rd_ptr_q];
    assign out_result    = head[31:0];
    assign out_exception = head[32];
    assign out_op        = head[33];
    assign out_is_zero   = (head[30:0] == 31'd0);
    assign out_sign      = head[31];

    assign count            = count_q;
    assign sticky_exception = sticky_q;
    assign exc_count        = exc_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear is applied first so an exception push in the same cycle wins.
    always_comb begin
        sticky_d = sticky_q;
        exc_d    = exc_q;
        if (clear_sticky) begin
            sticky_d = 1'b0;
            exc_d    = '0;
        end
        if (push && in_exception) begin
            sticky_d = 1'b1;
            if (exc_d != EXC_MAX) exc_d = exc_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
            exc_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
            exc_q    <= exc_d;
        end
    end

    // Storage is not reset; push is already blocked while rst is high.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_op, in_exception, in_result};
    end

endmodule

// File: tb/tb_fpu_result_queue.sv
// tb_fpu_result_queue: scoreboard bench for fpu_result_queue.
// Driver issues directed vectors; a negedge monitor checks each pop.
module tb_fpu_result_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_result;
    logic        in_exception, in_op;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_exception, out_op, out_is_zero, out_sign;
    logic [2:0]  count;
    logic        sticky_exception;
    logic [7:0]  exc_count;
    logic        clear_sticky;

    logic        b_in_valid, b_in_ready;
    logic        b_out_valid, b_out_exception, b_out_op;
    logic        b_out_is_zero, b_out_sign, b_sticky;
    logic [31:0] b_out_result;
    logic [2:0]  b_count;
    logic [1:0]  b_exc_count;

    int tests = 0;
    int fails = 0;
    logic [33:0] sb [$];

    always #5 clk = ~clk;

    fpu_result_queue #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_exception(in_exception), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_exception(out_exception),
        .out_op(out_op), .out_is_zero(out_is_zero), .out_sign(out_sign),
        .count(count), .sticky_exception(sticky_exception),
        .exc_count(exc_count), .clear_sticky(clear_sticky)
    );

    fpu_result_queue #(.DEPTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_result(32'h0), .in_exception(1'b1), .in_op(1'b0),
        .out_valid(b_out_valid), .out_ready(1'b1),
        .out_result(b_out_result), .out_exception(b_out_exception),
        .out_op(b_out_op), .out_is_zero(b_out_is_zero),
        .out_sign(b_out_sign), .count(b_count),
        .sticky_exception(b_sticky), .exc_count(b_exc_count),
        .clear_sticky(1'b0)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: record accepted pushes, check every pop against the model.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("pop_underflow", 64'd1, 64'd0);
                end else begin
                    logic [33:0] e;
                    e = sb.pop_front();
                    chk("pop_entry",
                        {28'd0, out_op, out_exception, out_result,
                         out_is_zero, out_sign},
                        {28'd0, e[33], e[32], e[31:0],
                         e[30:0] == 31'd0, e[31]});
                end
            end
            if (in_valid && in_ready)
                sb.push_back({in_op, in_exception, in_result});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] r, input logic e,
                        input logic o);
        in_valid     = 1'b1;
        in_result    = r;
        in_exception = e;
        in_op        = o;
        step();
        in_valid     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_result = '0;
        in_exception = 1'b0; in_op = 1'b0; out_ready = 1'b0;
        clear_sticky = 1'b0; b_in_valid = 1'b0;
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sticky", sticky_exception, 0);
        chk("rst_exc", exc_count, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1);

        // Order
        push(32'h40400000, 1'b0, 1'b0);
        chk("order_cnt1", count, 1);
        chk("order_valid", out_valid, 1);
        push(32'h3F800000, 1'b0, 1'b1);
        chk("order_cnt2", count, 2);
        push(32'h00000000, 1'b1, 1'b0);
        chk("order_cnt3", count, 3);
        out_ready = 1'b1;
        step();
        chk("order_pop_cnt2", count, 2);
        step();
        chk("order_pop_cnt1", count, 1);
        chk("order_zero", out_is_zero, 1);
        chk("order_exc", out_exception, 1);
        step();
        chk("order_pop_cnt0", count, 0);
        chk("order_empty", out_valid, 0);
        out_ready = 1'b0;

        // Fill and drain
        for (int i = 0; i < 4; i++)
            push(32'hC1000000 + i, 1'b0, i[0]);
        chk("full_cnt", count, 4);
        chk("full_in_ready", in_ready, 0);
        in_valid = 1'b1; in_result = 32'hDEADBEEF; out_ready = 1'b1;
        #1;
        chk("full_cnt_during", count, 4);
        step();
        in_valid = 1'b0;
        chk("full_after_pop_cnt", count, 3);
        chk("full_after_ready", in_ready, 1);
        step(); step(); step();
        chk("drain_cnt", count, 0);
        out_ready = 1'b0;

        // Streaming
        push(32'h00000100, 1'b0, 1'b0);
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            in_result = 32'h00000100 + i;
            in_op = i[0];
            step();
            chk("stream_cnt", count, 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drain", count, 0);

        // Status
        clear_sticky = 1'b1;
        step();
        clear_sticky = 1'b0;
        chk("clr_sticky", sticky_exception, 0);
        chk("clr_exc", exc_count, 0);
        for (int i = 0; i < 3; i++)
            push(32'h0, 1'b1, 1'b1);
        chk("stat_exc3", exc_count, 3);
        chk("stat_sticky", sticky_exception, 1);
        clear_sticky = 1'b1;
        push(32'h80000000, 1'b1, 1'b0);
        clear_sticky = 1'b0;
        chk("stat_exc_clr_set", exc_count, 1);
        chk("stat_sticky_clr_set", sticky_exception, 1);
        step(); step();
        chk("stat_drain", count, 0);
        out_ready = 1'b0;

        // Saturation at CNT_W = 2
        b_in_valid = 1'b1;
        step(); step(); step();
        chk("sat_exc3", b_exc_count, 3);
        step(); step();
        b_in_valid = 1'b0;
        chk("sat_exc5", b_exc_count, 3);
        chk("sat_sticky", b_sticky, 1);

        // Reset mid-operation
        push(32'h40000000, 1'b1, 1'b0);
        push(32'hBF800000, 1'b0, 1'b1);
        push(32'h41200000, 1'b0, 1'b0);
        chk("mid_cnt3", count, 3);
        rst = 1'b1; in_valid = 1'b1; in_result = 32'h12345678;
        out_ready = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        step();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        chk("mid_cnt", count, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_sticky", sticky_exception, 0);
        chk("mid_exc", exc_count, 0);
        chk("mid_in_ready", in_ready, 1);
        push(32'h3F000000, 1'b0, 1'b1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("final_cnt", count, 0);
        chk("sb_left", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
